// File: rtl/button_step_gen.sv
`default_nettype none
// ============================================================================
//  Module      : button_step_gen
//  Description : Turns two raw, bouncing push-buttons ("up" / "down") into
//                single-cycle step pulses for a downstream up/down decimal
//                counter. Each button is synchronized, debounced, and fed to
//                a small hold/lock state machine that emits a press pulse
//                followed by auto-repeat pulses while the button is held.
//                Pressing both buttons locks the outputs until both are
//                released.
//  Ports       : i_clk      - single clock, rising edge
//                i_rst      - synchronous active-high reset
//                i_btn_up   - raw asynchronous "increment" button, active-high
//                i_btn_down - raw asynchronous "decrement" button, active-high
//                o_plus     - one-cycle increment pulse (registered)
//                o_minus    - one-cycle decrement pulse (registered)
//                o_busy     - high while the state machine is not IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module button_step_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_up,
    input  logic i_btn_down,
    output logic o_plus,
    output logic o_minus,
    output logic o_busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int C_TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW     = $clog2(C_TMAX + 1);

    // The debounced level flips on the edge where the counter would reach
    // DEBOUNCE_CYCLES, i.e. when it already holds DEBOUNCE_CYCLES-1.
    localparam logic [CW-1:0] c_db_last   = CW'(DEBOUNCE_CYCLES - 1);
    // Repeat timer counts from 0 after a pulse; a pulse fires on the edge
    // where it holds (interval - 1), giving exactly "interval" clocks between
    // pulse edges.
    localparam logic [TW-1:0] c_rep_first = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] c_rep_next  = TW'(REPEAT_PERIOD - 1);

    // ------------------------------------------------------------------------
    // Per-button synchronizer + debouncer (index 0 = up, 1 = down)
    // ------------------------------------------------------------------------
    logic [1:0] w_raw;
    logic [1:0] w_deb;

    assign w_raw = {i_btn_down, i_btn_up};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic          r_sync1;
            logic          r_sync2;
            logic          r_deb;
            logic [CW-1:0] r_cnt;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_deb   <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_raw[gi];
                    r_sync2 <= r_sync1;
                    if (r_sync2 == r_deb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_db_last) begin
                        r_deb <= ~r_deb;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_deb[gi] = r_deb;
        end
    endgenerate

    logic w_u;
    logic w_d;

    assign w_u = w_deb[0];
    assign w_d = w_deb[1];

    // ------------------------------------------------------------------------
    // Hold / lock state machine
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_UP_HOLD   = 2'd1,
        ST_DOWN_HOLD = 2'd2,
        ST_LOCK      = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_next;
    logic          r_rep;        // first repeat already issued in this hold
    logic          w_rep_next;
    logic [TW-1:0] w_limit;
    logic          w_plus;
    logic          w_minus;
    logic          r_plus;
    logic          r_minus;
    logic          r_busy;

    assign w_limit = r_rep ? c_rep_next : c_rep_first;

    always_comb begin
        w_next_state = r_state;
        w_timer_next = '0;
        w_rep_next   = 1'b0;
        w_plus       = 1'b0;
        w_minus      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_u && w_d) begin
                    w_next_state = ST_LOCK;
                end else if (w_u) begin
                    w_next_state = ST_UP_HOLD;
                    w_plus       = 1'b1;
                end else if (w_d) begin
                    w_next_state = ST_DOWN_HOLD;
                    w_minus      = 1'b1;
                end
            end

            ST_UP_HOLD: begin
                if (w_d) begin
                    w_next_state = ST_LOCK;
                end else if (!w_u) begin
                    w_next_state = ST_IDLE;
                end else begin
                    // Staying in the hold: run the repeat timer. A pulse is
                    // deferred by one cycle if the output is still high, so
                    // pulses can never merge even for tiny repeat intervals.
                    w_rep_next   = r_rep;
                    w_timer_next = r_timer;
                    if (r_timer == w_limit) begin
                        if (!r_plus) begin
                            w_plus       = 1'b1;
                            w_timer_next = '0;
                            w_rep_next   = 1'b1;
                        end
                    end else begin
                        w_timer_next = r_timer + 1'b1;
                    end
                end
            end

            ST_DOWN_HOLD: begin
                if (w_u) begin
                    w_next_state = ST_LOCK;
                end else if (!w_d) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_rep_next   = r_rep;
                    w_timer_next = r_timer;
                    if (r_timer == w_limit) begin
                        if (!r_minus) begin
                            w_minus      = 1'b1;
                            w_timer_next = '0;
                            w_rep_next   = 1'b1;
                        end
                    end else begin
                        w_timer_next = r_timer + 1'b1;
                    end
                end
            end

            ST_LOCK: begin
                if (!w_u && !w_d) begin
                    w_next_state = ST_IDLE;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_rep   <= 1'b0;
            r_plus  <= 1'b0;
            r_minus <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_timer <= w_timer_next;
            r_rep   <= w_rep_next;
            r_plus  <= w_plus;
            r_minus <= w_minus;
            // Registered alongside the state so it always equals (state != IDLE).
            r_busy  <= (w_next_state != ST_IDLE);
        end
    end

    assign o_plus  = r_plus;
    assign o_minus = r_minus;
    assign o_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_button_step_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_step_gen
//  Description : Self-checking bench for button_step_gen. Expected pulses are
//                queued when a press is driven and popped as the DUT pulses;
//                o_busy is compared every cycle against the expected window.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_step_gen;

    localparam int C_DB  = 4;
    localparam int C_RD  = 10;
    localparam int C_RP  = 3;
    localparam int C_LAT = C_DB + 3;   // raw press edge -> pulse cycle

    logic clk = 1'b0;
    logic rst;
    logic btn_up;
    logic btn_down;
    logic plus;
    logic minus;
    logic busy;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        int cyc;
        bit is_plus;
    } exp_t;

    exp_t sb[$];

    button_step_gen #(
        .DEBOUNCE_CYCLES(C_DB),
        .REPEAT_DELAY   (C_RD),
        .REPEAT_PERIOD  (C_RP)
    ) u_dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_btn_up  (btn_up),
        .i_btn_down(btn_down),
        .o_plus    (plus),
        .o_minus   (minus),
        .o_busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, $signed(obs), $signed(exp), $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int cyc, input bit is_plus);
        exp_t e;
        e.cyc     = cyc;
        e.is_plus = is_plus;
        sb.push_back(e);
    endtask

    function automatic bit busy_exp(input int id, input int n);
        case (id)
            1:       return (n >= C_LAT && n < 15);
            3:       return (n >= C_LAT && n < 37);
            4:       return (n >= C_LAT && n < 37) || (n >= 47 && n < 56);
            5:       return (n >= C_LAT && n < 13) || (n >= 20 && n < 29);
            default: return 1'b0;
        endcase
    endfunction

    task automatic mon(input int id, input int n);
        exp_t e;
        chk_val($sformatf("busy s%0d c%0d", id, n), {31'd0, busy}, {31'd0, busy_exp(id, n)});
        if (plus || minus) begin
            chk_val("plus_minus_exclusive", {31'd0, plus & minus}, 32'd0);
            if (sb.size() == 0) begin
                chk_val($sformatf("unexpected_pulse s%0d", id), n, -1);
            end else begin
                e = sb.pop_front();
                chk_val($sformatf("pulse_cycle s%0d", id), n, e.cyc);
                chk_val($sformatf("pulse_is_plus s%0d c%0d", id, n), {31'd0, plus}, {31'd0, e.is_plus});
            end
        end
    endtask

    // Inputs for scenario cycle n; a value set here is "raised at edge n".
    task automatic drive(input int id, input int n);
        rst = 1'b0;
        case (id)
            1: begin  // clean press, released before the first repeat is due
                btn_up = (n < 8);
                if (n == 0) push(C_LAT, 1'b1);
            end
            2: begin  // bounce shorter than the debounce window
                btn_down = (n < 20) && (((n / 2) % 2) == 0);
            end
            3: begin  // auto-repeat; release at 30 debounces out at edge 36
                btn_up = (n < 30);
                if (n == 0) begin
                    push(C_LAT, 1'b1);
                    for (int c = C_LAT + C_RD; c < 37; c += C_RP) push(c, 1'b1);
                end
            end
            4: begin  // lock, then a fresh down press after full release
                btn_up   = (n < 20);
                btn_down = (n >= 9 && n < 30) || (n >= 40 && n < 49);
                if (n == 0)  push(C_LAT, 1'b1);
                if (n == 40) push(40 + C_LAT, 1'b0);
            end
            5: begin  // reset mid-hold, button kept pressed
                btn_down = (n < 22);
                rst      = (n == 12);
                if (n == 0)  push(C_LAT, 1'b0);
                if (n == 13) push(13 + C_LAT, 1'b0);
            end
            default: ;
        endcase
    endtask

    task automatic run(input int id, input int len);
        rst      = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick();
        chk_val($sformatf("reset_plus s%0d", id),  {31'd0, plus},  32'd0);
        chk_val($sformatf("reset_minus s%0d", id), {31'd0, minus}, 32'd0);
        chk_val($sformatf("reset_busy s%0d", id),  {31'd0, busy},  32'd0);
        rst = 1'b0;
        tick();  // scenario edge 0
        for (int n = 0; n < len; n++) begin
            mon(id, n);
            drive(id, n);
            tick();
        end
        chk_val($sformatf("pulses_outstanding s%0d", id), sb.size(), 32'd0);
        sb.delete();
    endtask

    initial begin
        rst      = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick();
        run(1, 24);
        run(2, 30);
        run(3, 44);
        run(4, 64);
        run(5, 36);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
